// File: rtl/bcd_to_bin.sv
// bcd_to_bin: three-digit BCD to 10-bit binary converter.
// Iterative reverse double-dabble, one shift/correct step per clock.
module bcd_to_bin (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [9:0] number,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]  state;
    logic [3:0]  cnt;
    logic [21:0] work;
    logic [21:0] shifted;
    logic [21:0] stepped;
    logic        err_pending;
    logic        bad_digit;

    assign bad_digit = (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9);

    // Shift first, then pull 3 out of any BCD field that landed at 8 or above.
    always_comb begin
        shifted = {1'b0, work[21:1]};
        stepped = shifted;
        if (shifted[21:18] >= 4'd8) stepped[21:18] = shifted[21:18] - 4'd3;
        if (shifted[17:14] >= 4'd8) stepped[17:14] = shifted[17:14] - 4'd3;
        if (shifted[13:10] >= 4'd8) stepped[13:10] = shifted[13:10] - 4'd3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            work        <= 22'd0;
            err_pending <= 1'b0;
            number      <= 10'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work        <= {hundreds, tens, ones, 10'd0};
                        err_pending <= bad_digit;
                        cnt         <= 4'd0;
                        busy        <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= stepped;
                    cnt  <= cnt + 4'd1;
                    if (cnt == 4'd9) begin
                        number <= err_pending ? 10'd0 : stepped[9:0];
                        error  <= err_pending;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: random and directed stimulus checked every cycle
// against a behavioural model of the converter.
module tb_bcd_to_bin;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] hundreds = 4'd0;
    logic [3:0] tens = 4'd0;
    logic [3:0] ones = 4'd0;
    logic [9:0] number;
    logic       busy;
    logic       done;
    logic       error;

    int n_chk = 0;
    int n_fail = 0;

    bcd_to_bin dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .hundreds(hundreds),
        .tens(tens),
        .ones(ones),
        .number(number),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an accepted request completes exactly 10 edges later.
    int cyc = 0;
    int due = 0;
    bit m_busy = 0;
    bit m_done = 0;
    bit m_err = 0;
    int m_num = 0;
    int p_num = 0;
    bit p_err = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_busy = 0;
            m_done = 0;
            m_err  = 0;
            m_num  = 0;
        end else begin
            m_done = 0;
            if (m_busy && cyc == due) begin
                m_busy = 0;
                m_done = 1;
                m_num  = p_num;
                m_err  = p_err;
            end else if (!m_busy && start) begin
                m_busy = 1;
                due    = cyc + 10;
                p_err  = (hundreds > 9) || (tens > 9) || (ones > 9);
                p_num  = p_err ? 0 : 100 * hundreds + 10 * tens + ones;
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("number", number, m_num);
            check("error", error, m_err);
        end
    end

    // Single pulsed conversion with literal expectations on result and latency.
    task automatic conv(input int h, input int t, input int o,
                        input int exp_num, input int exp_err);
        int k;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        hundreds = 4'(h);
        tens = 4'(t);
        ones = 4'(o);
        @(negedge clk);
        start = 1'b0;
        hundreds = 4'($urandom);
        tens = 4'($urandom);
        ones = 4'($urandom);
        k = 0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            k++;
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL conv_timeout: no done for %0d/%0d/%0d", h, t, o);
        end else begin
            check("conv_latency", k, 10);
            check("conv_number", number, exp_num);
            check("conv_error", error, exp_err);
            check("conv_busy_low", busy, 0);
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    initial begin
        int n;
        int k;
        bit seen;
        int vh[3];
        int vt[3];
        int vo[3];
        int ve[3];

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_number", number, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_error", error, 0);

        conv(9, 9, 9, 999, 0);

        // Back-to-back with start held high.
        vh = '{0, 5, 1};
        vt = '{0, 1, 0};
        vo = '{0, 2, 0};
        ve = '{0, 512, 100};
        @(negedge clk);
        start = 1'b1;
        hundreds = 4'(vh[0]);
        tens = 4'(vt[0]);
        ones = 4'(vo[0]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i < 2) begin
                hundreds = 4'(vh[i+1]);
                tens = 4'(vt[i+1]);
                ones = 4'(vo[i+1]);
            end
            k = 0;
            seen = 0;
            repeat (15) begin
                @(negedge clk);
                k++;
                if (done) begin
                    seen = 1;
                    break;
                end
            end
            if (i == 2) start = 1'b0;
            if (!seen) begin
                n_chk++;
                n_fail++;
                $display("FAIL b2b_timeout: conversion %0d", i);
            end else begin
                check("b2b_latency", k, 10);
                check("b2b_number", number, ve[i]);
            end
        end

        conv(2, 10, 3, 0, 1);
        conv(0, 4, 2, 42, 0);

        // Start while busy must be ignored.
        @(negedge clk);
        start = 1'b1;
        hundreds = 4'd7;
        tens = 4'd6;
        ones = 4'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        hundreds = 4'd1;
        tens = 4'd1;
        ones = 4'd1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            k++;
            if (done) begin
                seen = 1;
                break;
            end
        end
        check("ignore_seen", seen, 1);
        check("ignore_number", number, 765);
        count_dones(15, n);
        check("ignore_no_second_done", n, 0);

        // Abort mid-conversion.
        @(negedge clk);
        start = 1'b1;
        hundreds = 4'd3;
        tens = 4'd2;
        ones = 4'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_number", number, 0);
        count_dones(15, n);
        check("abort_no_done", n, 0);
        conv(3, 2, 1, 321, 0);

        for (int h = 0; h < 10; h++)
            for (int t = 0; t < 10; t++)
                for (int o = 0; o < 10; o++)
                    conv(h, t, o, 100 * h + 10 * t + o, 0);

        // Random traffic, including invalid digits and occasional resets.
        repeat (4000) begin
            @(negedge clk);
            start = ($urandom % 3) == 0;
            hundreds = 4'($urandom);
            tens = 4'($urandom);
            ones = 4'($urandom);
            rst = ($urandom % 250) == 0;
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (15) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
